if_fetch_unit: RTL

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, buffers

---
 rtl/if_fetch_unit_pkg.sv | 9 +
 rtl/if_fetch_unit_if.sv | 16 +
 rtl/if_fetch_unit_fetch_buf.sv | 54 +++++
 rtl/if_fetch_unit.sv | 96 +++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared widths, reset vector, NOP encoding and queue-count type for the fetch stage.
package if_fetch_unit_pkg;
  localparam int ADDR_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam logic [ADDR_BUS_W-1:0] RESET_PC_DEF = 32'hBFC00000;
  localparam logic [INST_BUS_W-1:0] NOP_INST = '0;

  typedef logic [1:0] qcount_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int INST_W = INST_BUS_W
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic              rvalid;
  logic [INST_W-1:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/if_fetch_unit_fetch_buf.sv
// 2-entry FIFO of fetched {addr,inst} words with synchronous clear; slot0 is always the head.
// Latency: a pushed word is visible at the head the cycle after its write edge.
// Backpressure: none inside; the caller never pushes when full nor pops when empty.
module if_fetch_unit_fetch_buf
  import if_fetch_unit_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output qcount_t           count
);
  logic [DATA_W-1:0] slot0;
  logic [DATA_W-1:0] slot1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= din;
          else               slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever survives the pop.
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= din;
          end else begin
            slot0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, queues words for IF/ID.
// Latency: accept at n, rvalid at n+1, head visible at n+2; sustains 1 instruction/cycle.
// Backpressure: stall_if holds the head; requests stop once queue plus in-flight slot is full.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_BUS_W,
  parameter int                INST_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_if,
  input  logic                   branch_flag_i,
  input  logic [ADDR_W-1:0]      branch_target_i,
  input  logic                   flush_i,
  input  logic [ADDR_W-1:0]      flush_pc_i,
  if_fetch_unit_if.master        imem,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [INST_W-1:0]      inst_o,
  output logic                   stall_req_o
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic              pending;
  logic              kill;
  qcount_t           count;
  entry_t            head;
  entry_t            wr_entry;
  logic              pop;
  logic              redir;
  logic              push;
  logic              accept;
  logic              fetch_ok;
  logic [2:0]        occupancy;

  assign pop   = (count != 2'd0) && !stall_if && !flush_i;
  assign redir = branch_flag_i && pop;

  // The in-flight slot is reserved so its response always has room to land.
  assign occupancy = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
  assign fetch_ok  = !flush_i && !redir && (!pending || imem.rvalid) && (occupancy < 3'd2);

  assign imem.req  = fetch_ok && !rst;
  assign imem.addr = {pc[ADDR_W-1:2], 2'b00};
  assign accept    = imem.req && imem.ready;

  assign push     = imem.rvalid && !kill && !redir && !flush_i;
  assign wr_entry = {req_addr, imem.rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_addr <= '0;
      pending  <= 1'b0;
      kill     <= 1'b0;
    end else begin
      if (flush_i)     pc <= flush_pc_i;
      else if (redir)  pc <= branch_target_i;
      else if (accept) pc <= pc + ADDR_W'(4);

      if (accept) begin
        pending  <= 1'b1;
        req_addr <= imem.addr;
      end else if (imem.rvalid) begin
        pending  <= 1'b0;
      end

      // A redirect with a word still in flight must discard that word when it arrives.
      if (imem.rvalid)                         kill <= 1'b0;
      else if ((redir || flush_i) && pending)  kill <= 1'b1;
    end
  end

  if_fetch_unit_fetch_buf #(
    .DATA_W(ADDR_W + INST_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush_i || redir),
    .din   (wr_entry),
    .head  (head),
    .count (count)
  );

  assign stall_req_o = (count == 2'd0);
  assign addr_o      = stall_req_o ? '0 : head.addr;
  assign inst_o      = stall_req_o ? INST_W'(NOP_INST) : head.inst;
endmodule
